// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-locked two-requester arbiter in front of the UART transmitter
module uart_tx_arbiter #(
    parameter logic [7:0] LOCK_CHAR = 8'h0A,
    parameter int         TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       locked,
    output logic       owner
);
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;

    logic             space;
    logic             sel;
    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             accept;
    logic             is_lock;

    // While locked only the owner is ever selected, so the other ready stays low.
    always_comb begin
        space = !tx_valid_q || tx_ready;
        if (state_q == LOCKED) begin
            sel = owner_q;
        end else if (req0_valid && req1_valid) begin
            sel = prio_q;
        end else begin
            sel = req1_valid;
        end
        sel_valid  = sel ? req1_valid : req0_valid;
        sel_data   = sel ? req1_data : req0_data;
        req0_ready = !rst && space && !sel;
        req1_ready = !rst && space && sel;
        accept     = !rst && space && sel_valid;
        is_lock    = (sel_data == LOCK_CHAR);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    owner_d = sel;
                    if (is_lock) begin
                        prio_d = !sel;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    cnt_d = '0;
                    if (is_lock) begin
                        state_d = IDLE;
                        prio_d  = !owner_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Owner stalled too long: hand the transmitter to the other side.
                    state_d = IDLE;
                    prio_d  = !owner_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-entry output register; a drain and a refill can share an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else if (accept) begin
            tx_data_q  <= sel_data;
            tx_valid_q <= 1'b1;
        end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign locked   = (state_q == LOCKED);
    assign owner    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int         TIMEOUT   = 16;
    localparam logic [7:0] LOCK_CHAR = 8'h0A;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic [7:0] req0_data  = 8'h00;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data  = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready   = 1'b1;
    logic       locked;
    logic       owner;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.LOCK_CHAR(LOCK_CHAR), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .locked     (locked),
        .owner      (owner)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] tx_seen[$];
    logic       fire0 = 1'b0;
    logic       fire1 = 1'b0;

    logic [7:0] exp_msg [4] = '{8'h4F, 8'h4B, 8'h0A, 8'h43};
    int         rr_owner[4] = '{0, 1, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply();
        req0_valid = (q0.size() != 0);
        req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
        req1_valid = (q1.size() != 0);
        req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #2;
    endtask

    // Requester drivers: head of each queue is presented until handshaken.
    always @(posedge clk) begin
        #1;
        if (fire0 && q0.size() != 0) void'(q0.pop_front());
        if (fire1 && q1.size() != 0) void'(q1.pop_front());
        apply();
        #2;
        apply();
    end

    // Reference model: who may send, what sits in the output slot, who holds the line.
    int         m_holder = -1;
    logic       m_last   = 1'b0;
    logic       m_fav    = 1'b0;
    int         m_stall  = 0;
    logic [7:0] m_out[$];
    logic [7:0] m_shown  = 8'h00;

    function automatic int pick();
        if (m_holder >= 0) return m_holder;
        if (req0_valid && req1_valid) return m_fav ? 1 : 0;
        return req1_valid ? 1 : 0;
    endfunction

    function automatic logic room();
        return (m_out.size() == 0) || tx_ready;
    endfunction

    always @(posedge clk) begin
        int         w;
        logic       took;
        logic [7:0] b;
        if (rst) begin
            m_holder = -1;
            m_last   = 1'b0;
            m_fav    = 1'b0;
            m_stall  = 0;
            m_out.delete();
            m_shown  = 8'h00;
        end else begin
            w    = pick();
            took = room() && ((w == 1) ? req1_valid : req0_valid);
            b    = (w == 1) ? req1_data : req0_data;
            if (m_out.size() != 0 && tx_ready) void'(m_out.pop_front());
            if (took) begin
                m_out.push_back(b);
                m_shown = b;
            end
            if (m_holder < 0) begin
                if (took) begin
                    m_last = w[0];
                    if (b == LOCK_CHAR) begin
                        m_fav = (w == 0);
                    end else begin
                        m_holder = w;
                        m_stall  = 0;
                    end
                end
            end else if (took) begin
                m_stall = 0;
                if (b == LOCK_CHAR) begin
                    m_fav    = (m_holder == 0);
                    m_holder = -1;
                end
            end else if (m_stall == TIMEOUT - 1) begin
                m_fav    = (m_holder == 0);
                m_holder = -1;
                m_stall  = 0;
            end else begin
                m_stall++;
            end
        end
    end

    always @(negedge clk) begin
        fire0 = req0_valid && req0_ready;
        fire1 = req1_valid && req1_ready;
        if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
        chk("model_req0_ready", 32'(req0_ready), 32'(!rst && room() && pick() == 0));
        chk("model_req1_ready", 32'(req1_ready), 32'(!rst && room() && pick() == 1));
        chk("model_tx_valid", 32'(tx_valid), 32'(m_out.size() != 0));
        chk("model_tx_data", 32'(tx_data), 32'(m_shown));
        chk("model_locked", 32'(locked), 32'(m_holder >= 0));
        chk("model_owner", 32'(owner), 32'(m_last));
    end

    initial begin
        int   n;
        logic prev;

        // Reset held 10 cycles with both requesters offering "\n" twice.
        q0 = '{8'h0A, 8'h0A};
        q1 = '{8'h0A, 8'h0A};
        repeat (5) tick();
        settle();
        chk("rst_req0_ready", 32'(req0_ready), 32'h0);
        chk("rst_req1_ready", 32'(req1_ready), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_locked", 32'(locked), 32'h0);
        repeat (5) tick();
        rst = 1'b0;
        tx_seen.delete();
        settle();
        chk("first_grant_req0", 32'(req0_ready), 32'h1);
        chk("first_grant_req1", 32'(req1_ready), 32'h0);

        // Round-robin on single-byte messages.
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("rr_owner", 32'(owner), rr_owner[i]);
            chk("rr_tx_valid", 32'(tx_valid), 32'h1);
            chk("rr_tx_data", 32'(tx_data), 32'h0A);
        end
        tick();
        settle();
        chk("rr_transfers", 32'(tx_seen.size()), 32'd4);
        chk("rr_tx_idle", 32'(tx_valid), 32'h0);
        chk("rr_locked", 32'(locked), 32'h0);

        // Message lock: "OK\n" from req0, "C" from req1 waits.
        tick();
        q0 = '{8'h4F, 8'h4B, 8'h0A};
        tx_seen.delete();
        tick();
        q1.push_back(8'h43);
        settle();
        chk("lock_req1_blocked_1", 32'(req1_ready), 32'h0);
        chk("lock_locked", 32'(locked), 32'h1);
        tick();
        settle();
        chk("lock_req1_blocked_2", 32'(req1_ready), 32'h0);
        tick();
        settle();
        chk("lock_req1_granted", 32'(req1_ready), 32'h1);
        chk("lock_released", 32'(locked), 32'h0);
        tick();
        q1.push_back(8'h0A);
        settle();
        chk("lock_req1_locked", 32'(locked), 32'h1);
        chk("lock_req1_owner", 32'(owner), 32'h1);
        chk("lock_req1_data", 32'(tx_data), 32'h43);
        tick();
        settle();
        chk("lock_transfers", 32'(tx_seen.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("lock_tx_seq", (i < tx_seen.size()) ? 32'(tx_seen[i]) : 32'hFFFF_FFFF, 32'(exp_msg[i]));
        end

        // Backpressure: "AB" with the transmitter stalled 5 cycles.
        tick();
        tick();
        q0 = '{8'h41, 8'h42};
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_tx_data_hold", 32'(tx_data), 32'h41);
            chk("bp_tx_valid_hold", 32'(tx_valid), 32'h1);
            chk("bp_req0_stalled", 32'(req0_ready), 32'h0);
            tick();
        end
        tx_ready = 1'b1;
        settle();
        chk("bp_req0_refill", 32'(req0_ready), 32'h1);
        chk("bp_tx_data_still", 32'(tx_data), 32'h41);
        tick();
        q0.push_back(8'h0A);
        settle();
        chk("bp_second_byte", 32'(tx_data), 32'h42);
        chk("bp_second_valid", 32'(tx_valid), 32'h1);
        tick();

        // Timeout: req1 sends 0x50 then goes quiet while req0 waits with 0x30.
        tick();
        q1 = '{8'h50};
        q0 = '{8'h30};
        tick();
        settle();
        chk("to_owner", 32'(owner), 32'h1);
        chk("to_locked", 32'(locked), 32'h1);
        n    = 0;
        prev = locked;
        while (!req0_ready && n < 40) begin
            prev = locked;
            tick();
            settle();
            n++;
        end
        chk("to_grant_delay", 32'(n), 32'd16);
        chk("to_locked_before", 32'(prev), 32'h1);
        chk("to_locked_fall", 32'(locked), 32'h0);
        tick();
        q0.push_back(8'h0A);
        settle();
        chk("to_req0_owner", 32'(owner), 32'h0);
        chk("to_req0_data", 32'(tx_data), 32'h30);

        // Reset in the middle of a req1 message with a byte parked in the output.
        tick();
        q1 = '{8'h52, 8'h53};
        tick();
        q0.push_back(8'h31);
        tx_ready = 1'b0;
        rst      = 1'b1;
        settle();
        chk("mid_locked_before", 32'(locked), 32'h1);
        chk("mid_owner_before", 32'(owner), 32'h1);
        chk("mid_tx_valid_before", 32'(tx_valid), 32'h1);
        chk("mid_req0_ready_rst", 32'(req0_ready), 32'h0);
        chk("mid_req1_ready_rst", 32'(req1_ready), 32'h0);
        tick();
        chk("mid_tx_valid_after", 32'(tx_valid), 32'h0);
        chk("mid_locked_after", 32'(locked), 32'h0);
        chk("mid_tx_data_after", 32'(tx_data), 32'h00);
        rst      = 1'b0;
        tx_ready = 1'b1;
        settle();
        chk("mid_req0_wins", 32'(req0_ready), 32'h1);
        chk("mid_req1_waits", 32'(req1_ready), 32'h0);
        tick();
        settle();
        chk("mid_owner_req0", 32'(owner), 32'h0);
        chk("mid_tx_data_req0", 32'(tx_data), 32'h31);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
